// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the fetch PC, issues credit-limited word reads and
// buffers responses with their PCs. Define IFU_BYPASS_EN for zero-latency empty-FIFO bypass.
module ifu_fetch #(
  parameter int              XLEN       = 64,
  parameter int              ILEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 64'h8000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            req_valid_o,
  input  logic            req_ready_i,
  output logic [XLEN-1:0] req_addr_o,
  input  logic            resp_valid_i,
  input  logic [ILEN-1:0] resp_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [ILEN-1:0] out_instr_o,
  output logic [XLEN-1:0] out_pc_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [XLEN-1:0] r_buf_pc    [FIFO_DEPTH];
  logic [ILEN-1:0] r_buf_instr [FIFO_DEPTH];

  logic [CW:0]     w_inflight;
  logic            w_credit;
  logic            w_fire;
  logic            w_resp_acc;
  logic            w_drop;
  logic            w_fifo_empty;
  logic            w_bypass;
  logic            w_bypass_take;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_out_next;
  logic [XLEN-1:0] w_target;
  logic            w_unused_ok;

  assign w_unused_ok  = ^redirect_pc_i[1:0];
  assign w_target     = {redirect_pc_i[XLEN-1:2], 2'b00};

  // Reserve a FIFO slot for every request in flight so responses never overflow
  assign w_inflight   = {1'b0, r_outstanding} + {1'b0, r_count};
  assign w_credit     = w_inflight < (CW+1)'(FIFO_DEPTH);
  assign req_valid_o  = !rst && !redirect_i && w_credit;
  assign req_addr_o   = r_fetch_pc;
  assign w_fire       = req_valid_o && req_ready_i;

  assign w_resp_acc   = resp_valid_i && (r_outstanding != '0);
  assign w_drop       = w_resp_acc && (r_drop_cnt != '0);
  assign w_out_next   = r_outstanding + CW'(w_fire) - CW'(w_resp_acc);
  assign w_fifo_empty = (r_count == '0);

`ifdef IFU_BYPASS_EN
  assign w_bypass     = !rst && w_fifo_empty && (r_drop_cnt == '0) && !redirect_i && w_resp_acc;
`else
  assign w_bypass     = 1'b0;
`endif
  assign w_bypass_take = w_bypass && out_ready_i;

  assign w_push       = !rst && !redirect_i && w_resp_acc && !w_drop && !w_bypass_take;
  assign w_pop        = !rst && !w_fifo_empty && out_ready_i;

  assign out_valid_o  = !rst && (!w_fifo_empty || w_bypass);
  assign out_instr_o  = w_bypass ? resp_data_i : r_buf_instr[r_rptr];
  assign out_pc_o     = w_bypass ? r_resp_pc   : r_buf_pc[r_rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
    end else if (redirect_i) begin
      // Everything still in flight after this edge belongs to the old path
      r_fetch_pc    <= w_target;
      r_resp_pc     <= w_target;
      r_outstanding <= w_out_next;
      r_drop_cnt    <= w_out_next;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
    end else begin
      if (w_fire) r_fetch_pc <= r_fetch_pc + XLEN'(4);
      r_outstanding <= w_out_next;
      if (w_drop) r_drop_cnt <= r_drop_cnt - CW'(1);
      if (w_resp_acc && !w_drop) r_resp_pc <= r_resp_pc + XLEN'(4);
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_pc[r_wptr]    <= r_resp_pc;
      r_buf_instr[r_wptr] <= resp_data_i;
    end
  end

endmodule
